// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores on word-only memory, sub-word stores by read-modify-write; define MISALIGN_TRAP_EN to trap misaligned/illegal accesses
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state, state_nx;
  logic              we;
  logic [2:0]        f3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, rbuf, ld_data;
  logic [1:0]        cnt, sz, in_sz;
  logic              in_trap, rd_last;
  logic [7:0]        b_sel;
  logic [15:0]       h_sel;
  logic [4:0]        b_sh, h_sh;
  // access size: 0 byte, 1 halfword, 2 word (illegal encodings fall back to word)
  function automatic logic [1:0] kind(input logic w, input logic [2:0] f);
    kind = (f == 3'b000 || (!w && f == 3'b100)) ? 2'd0 :
           (f == 3'b001 || (!w && f == 3'b101)) ? 2'd1 : 2'd2;
  endfunction
  assign in_sz = kind(req_we, req_funct3);
  assign sz = kind(we, f3);
`ifdef MISALIGN_TRAP_EN
  logic in_ill;
  assign in_ill = in_sz == 2'd2 && req_funct3 != 3'b010;
  assign in_trap = in_ill || (in_sz == 2'd1 && req_addr[0]) || (in_sz == 2'd2 && req_addr[1:0] != 2'b00);
`else
  assign in_trap = 1'b0;
`endif
  assign rd_last = cnt == 2'(READ_LAT);
  assign b_sh = {addr[1:0], 3'b000};
  assign h_sh = {addr[1], 4'b0000};
  assign b_sel = 8'(mem_rdata >> b_sh);
  assign h_sel = 16'(mem_rdata >> h_sh);
  assign ld_data = sz == 2'd0 ? (f3[2] ? {24'd0, b_sel} : {{24{b_sel[7]}}, b_sel}) :
                   sz == 2'd1 ? (f3[2] ? {16'd0, h_sel} : {{16{h_sel[15]}}, h_sel}) : mem_rdata;
  assign mem_wdata = sz == 2'd0 ? (rbuf & ~(32'hFF << b_sh)) | ({24'd0, wdata[7:0]} << b_sh) :
                     sz == 2'd1 ? (rbuf & ~(32'hFFFF << h_sh)) | ({16'd0, wdata[15:0]} << h_sh) : wdata;
  assign mem_addr = {addr[ADDR_W-1:2], 2'b00};
  assign req_ready = rst_n && state == IDLE;
  assign mem_read = rst_n && state == RD;
  assign mem_write = rst_n && state == WR;
  assign resp_valid = rst_n && state == RESP;
  // next-state: full words store directly, everything else reads first
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = in_trap ? RESP : (req_we && in_sz == 2'd2) ? WR : RD;
      RD: if (rd_last) state_nx = we ? WR : RESP;
      WR: state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  // request latch, read wait counter, read buffer and response registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      we <= 1'b0;
      f3 <= 3'd0;
      addr <= '0;
      wdata <= 32'd0;
      rbuf <= 32'd0;
      cnt <= 2'd0;
      resp_rdata <= 32'd0;
      resp_err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we <= req_we;
        f3 <= req_funct3;
        addr <= req_addr;
        wdata <= req_wdata;
      end
      if (state == RD) begin
        cnt <= rd_last ? 2'd0 : cnt + 2'd1;
        if (rd_last) rbuf <= mem_rdata;
      end
      if (state_nx == RESP && state != RESP) begin
        resp_rdata <= (state == RD && !we) ? ld_data : 32'd0;
        resp_err <= state == IDLE;
      end
    end
endmodule
